// File: rtl/lcd_frame_reader.sv
// lcd_frame_reader: LCD panel timing generator that pulls RGB565 pixels from the SDRAM read FIFO,
// with a colour-bar bring-up pattern and a per-frame FIFO underflow flag.
module lcd_frame_reader #(
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int H_ACTIVE = 480,
  parameter int H_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FRONT  = 2,
  parameter int BAR_W    = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pat_en,
  input  logic [15:0] rdfifo_rddb,
  input  logic        rdfifo_empty,
  output logic        rdfifo_rdreq,
  output logic        rdfifo_clr,
  output logic        lcd_clk,
  output logic        lcd_en,
  output logic        lcd_hsy,
  output logic        lcd_vsy,
  output logic [4:0]  lcd_db_r,
  output logic [5:0]  lcd_db_g,
  output logic [4:0]  lcd_db_b,
  output logic        frame_start,
  output logic        underflow
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BCW     = $clog2(BAR_W + 1);
  localparam logic [HW-1:0] H_SY   = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ST   = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_END  = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_SY   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ST   = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(BAR_W - 1);
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [2:0]     bsel_q, bsel_d, bar_q;
  logic           h_act, v_act, rd, frame_d;
  logic           hsy_q, vsy_q, en_q, clr_q, fs_q, uf_q, rd_q, empty_q, pat_q;
  logic [15:0]    rgb;

  always_comb begin
    h_act   = (hcnt_q >= H_ST) && (hcnt_q < H_END);
    v_act   = (vcnt_q >= V_ST) && (vcnt_q < V_END);
    rd      = h_act & v_act & ~pat_en;
    frame_d = (hcnt_q == '0) && (vcnt_q == '0);
    hcnt_d  = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
    vcnt_d  = (hcnt_q != H_LAST) ? vcnt_q : (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    // bar counters track the pixel presented in the next cycle and restart every line
    bcnt_d  = (!h_act || bcnt_q == B_LAST) ? '0 : bcnt_q + 1'b1;
    bsel_d  = !h_act ? '0 : (bcnt_q == B_LAST) ? bsel_q + 1'b1 : bsel_q;
    rgb     = !en_q ? '0 : pat_q ? BARS[bar_q] : (rd_q & empty_q) ? '0 : rdfifo_rddb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      bcnt_q  <= '0;
      bsel_q  <= '0;
      bar_q   <= '0;
      hsy_q   <= 1'b1;
      vsy_q   <= 1'b1;
      en_q    <= 1'b0;
      clr_q   <= 1'b1;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      rd_q    <= 1'b0;
      empty_q <= 1'b0;
      pat_q   <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      bcnt_q  <= bcnt_d;
      bsel_q  <= bsel_d;
      bar_q   <= bsel_q;
      hsy_q   <= ~(hcnt_q < H_SY);
      vsy_q   <= ~(vcnt_q < V_SY);
      en_q    <= h_act & v_act;
      clr_q   <= vcnt_q < V_SY;
      fs_q    <= frame_d;
      // a new underflow wins over the frame-start clear
      uf_q    <= (rd & rdfifo_empty) | (uf_q & ~frame_d);
      rd_q    <= rd;
      empty_q <= rdfifo_empty;
      pat_q   <= pat_en;
    end
  end

  assign rdfifo_rdreq = rd;
  assign rdfifo_clr   = clr_q;
  assign lcd_clk      = ~clk;
  assign lcd_en       = en_q;
  assign lcd_hsy      = hsy_q;
  assign lcd_vsy      = vsy_q;
  assign lcd_db_r     = rgb[15:11];
  assign lcd_db_g     = rgb[10:5];
  assign lcd_db_b     = rgb[4:0];
  assign frame_start  = fs_q;
  assign underflow    = uf_q;
endmodule

// File: tb/tb_lcd_frame_reader.sv
// tb_lcd_frame_reader: randomized checks of lcd_frame_reader against a frame-position reference model,
// using a reduced raster for the main instance plus the tiny and default rasters.
module tb_lcd_frame_reader;
  localparam int HS = 5, HB = 3, HA = 32, HF = 2;
  localparam int VS = 3, VB = 2, VA = 6, VF = 2;
  localparam int BW = 4;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FR = HT * VT;

  logic clk = 1'b0, rst_n = 1'b0, pat_en = 1'b0, empty = 1'b0;
  logic [15:0] rddb = '0;
  logic rdreq, clr, lclk, en, hsy, vsy, fs, uf;
  logic [4:0] r, b;
  logic [5:0] g;
  logic s_pat = 1'b0, s_empty = 1'b0;
  logic [15:0] s_rddb = 16'h1234;
  logic s_rdreq, s_clr, s_lclk, s_en, s_hsy, s_vsy, s_fs, s_uf;
  logic [4:0] s_r, s_b;
  logic [5:0] s_g;
  logic d_rdreq, d_clr, d_lclk, d_en, d_hsy, d_vsy, d_fs, d_uf;
  logic [4:0] d_r, d_b;
  logic [5:0] d_g;

  int errors = 0, checks = 0, mt = 0, e_h = 0, e_v = 0;
  logic e_hsy, e_vsy, e_en, e_clr, e_fs, e_uf, got_first;
  logic [15:0] e_rgb, word, first_word, rddb_val;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  always #5 clk = ~clk;

  lcd_frame_reader #(.H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF), .BAR_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .pat_en(pat_en), .rdfifo_rddb(rddb), .rdfifo_empty(empty),
    .rdfifo_rdreq(rdreq), .rdfifo_clr(clr), .lcd_clk(lclk), .lcd_en(en), .lcd_hsy(hsy),
    .lcd_vsy(vsy), .lcd_db_r(r), .lcd_db_g(g), .lcd_db_b(b), .frame_start(fs), .underflow(uf));

  lcd_frame_reader #(.H_SYNC(1), .H_BACK(1), .H_ACTIVE(8), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1), .BAR_W(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .pat_en(s_pat), .rdfifo_rddb(s_rddb), .rdfifo_empty(s_empty),
    .rdfifo_rdreq(s_rdreq), .rdfifo_clr(s_clr), .lcd_clk(s_lclk), .lcd_en(s_en), .lcd_hsy(s_hsy),
    .lcd_vsy(s_vsy), .lcd_db_r(s_r), .lcd_db_g(s_g), .lcd_db_b(s_b), .frame_start(s_fs), .underflow(s_uf));

  lcd_frame_reader dut_d (
    .clk(clk), .rst_n(rst_n), .pat_en(s_pat), .rdfifo_rddb(s_rddb), .rdfifo_empty(s_empty),
    .rdfifo_rdreq(d_rdreq), .rdfifo_clr(d_clr), .lcd_clk(d_lclk), .lcd_en(d_en), .lcd_hsy(d_hsy),
    .lcd_vsy(d_vsy), .lcd_db_r(d_r), .lcd_db_g(d_g), .lcd_db_b(d_b), .frame_start(d_fs), .underflow(d_uf));

  function automatic logic hact(int h);
    return h >= HS + HB && h < HS + HB + HA;
  endfunction

  function automatic logic vact(int v);
    return v >= VS + VB && v < VS + VB + VA;
  endfunction

  function automatic logic exp_rd();
    return hact(mt % HT) && vact((mt / HT) % VT) && !pat_en;
  endfunction

  // Advance one clock: derive registered expectations from the raster position mt and act as the FIFO.
  task automatic tick();
    logic rdp;
    @(posedge clk);
    rddb_val = 16'($urandom);
    if (!rst_n) begin
      {e_hsy, e_vsy, e_en, e_clr, e_fs, e_uf} = 6'b110100;
      e_rgb = '0;
      got_first = 1'b0;
      mt = 0;
    end else begin
      e_h   = mt % HT;
      e_v   = (mt / HT) % VT;
      rdp   = hact(e_h) && vact(e_v) && !pat_en;
      e_hsy = !(e_h < HS);
      e_vsy = !(e_v < VS);
      e_en  = hact(e_h) && vact(e_v);
      e_clr = e_v < VS;
      e_fs  = e_h == 0 && e_v == 0;
      if (e_fs) got_first = 1'b0;
      e_uf  = (rdp && empty) || (e_uf && !e_fs);
      if (!e_en || (rdp && empty)) e_rgb = '0;
      else if (pat_en) e_rgb = bars[(e_h - HS - HB) / BW];
      else begin
        e_rgb = word;
        rddb_val = word;
        if (!got_first) first_word = word;
        got_first = 1'b1;
        word = word + 16'd1;
      end
      mt++;
    end
    #1 rddb = rddb_val;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pat_en = 1'b0; empty = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks += 9;
    if (rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq got=%b exp=0", rdreq); end
    if (clr !== 1'b1) begin errors++; $display("FAIL reset_clr got=%b exp=1", clr); end
    if (en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", en); end
    if (hsy !== 1'b1) begin errors++; $display("FAIL reset_hsy got=%b exp=1", hsy); end
    if (vsy !== 1'b1) begin errors++; $display("FAIL reset_vsy got=%b exp=1", vsy); end
    if ({r, g, b} !== 16'h0) begin errors++; $display("FAIL reset_rgb got=%h exp=0000", {r, g, b}); end
    if (fs !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", fs); end
    if (uf !== 1'b0) begin errors++; $display("FAIL reset_uf got=%b exp=0", uf); end
    if (lclk !== ~clk) begin errors++; $display("FAIL reset_lcd_clk got=%b exp=%b", lclk, ~clk); end
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (fs !== 1'b1) begin errors++; $display("FAIL first_frame_start got=%b exp=1", fs); end
  endtask

  task automatic test_timing();
    int nrd = 0, nen = 0, nhs = 0, nvs = 0, ncl = 0;
    pat_en = 1'b0; empty = 1'b0;
    repeat (FR) begin
      tick();
      @(negedge clk);
      checks += 6;
      if (hsy !== e_hsy) begin errors++; $display("FAIL timing_hsy mt=%0d got=%b exp=%b", mt, hsy, e_hsy); end
      if (vsy !== e_vsy) begin errors++; $display("FAIL timing_vsy mt=%0d got=%b exp=%b", mt, vsy, e_vsy); end
      if (en !== e_en) begin errors++; $display("FAIL timing_en mt=%0d got=%b exp=%b", mt, en, e_en); end
      if (clr !== e_clr) begin errors++; $display("FAIL timing_clr mt=%0d got=%b exp=%b", mt, clr, e_clr); end
      if (fs !== e_fs) begin errors++; $display("FAIL timing_fs mt=%0d got=%b exp=%b", mt, fs, e_fs); end
      if (rdreq !== exp_rd()) begin errors++; $display("FAIL timing_rdreq mt=%0d got=%b exp=%b", mt, rdreq, exp_rd()); end
      nrd += int'(rdreq); nen += int'(en); nhs += int'(!hsy); nvs += int'(!vsy); ncl += int'(clr);
    end
    checks += 5;
    if (nrd != HA * VA) begin errors++; $display("FAIL reads_per_frame got=%0d exp=%0d", nrd, HA * VA); end
    if (nen != HA * VA) begin errors++; $display("FAIL en_per_frame got=%0d exp=%0d", nen, HA * VA); end
    if (nhs != HS * VT) begin errors++; $display("FAIL hsy_low_per_frame got=%0d exp=%0d", nhs, HS * VT); end
    if (nvs != VS * HT) begin errors++; $display("FAIL vsy_low_per_frame got=%0d exp=%0d", nvs, VS * HT); end
    if (ncl != VS * HT) begin errors++; $display("FAIL clr_per_frame got=%0d exp=%0d", ncl, VS * HT); end
  endtask

  task automatic test_video();
    pat_en = 1'b0; empty = 1'b0;
    repeat (2 * FR) begin
      tick();
      @(negedge clk);
      checks += 2;
      if ({r, g, b} !== e_rgb) begin errors++; $display("FAIL video_rgb mt=%0d got=%h exp=%h", mt, {r, g, b}, e_rgb); end
      if (uf !== 1'b0) begin errors++; $display("FAIL video_uf mt=%0d got=%b exp=0", mt, uf); end
      if (e_en && e_h == HS + HB && e_v == VS + VB) begin
        checks++;
        if ({r, g, b} !== first_word) begin errors++; $display("FAIL first_pixel got=%h exp=%h", {r, g, b}, first_word); end
      end
    end
  endtask

  task automatic test_underflow();
    int rises = 0, falls = 0;
    logic last = 1'b0;
    pat_en = 1'b0;
    repeat (2 * FR + HT) begin
      tick();
      empty = (mt % HT == HS + HB + 10) && ((mt / HT) % VT == VS + VB + 2);
      @(negedge clk);
      checks += 2;
      if ({r, g, b} !== e_rgb) begin errors++; $display("FAIL uf_rgb mt=%0d got=%h exp=%h", mt, {r, g, b}, e_rgb); end
      if (uf !== e_uf) begin errors++; $display("FAIL uf_flag mt=%0d got=%b exp=%b", mt, uf, e_uf); end
      if (e_uf && !last) rises++;
      if (!e_uf && last) begin
        falls++;
        checks++;
        if (fs !== 1'b1) begin errors++; $display("FAIL uf_clear_at_fs got_fs=%b exp=1", fs); end
      end
      last = e_uf;
    end
    empty = 1'b0;
    checks++;
    if (rises < 2 || falls < 1) begin errors++; $display("FAIL uf_events rises=%0d falls=%0d exp>=2,>=1", rises, falls); end
  endtask

  task automatic test_random_empty();
    pat_en = 1'b0;
    repeat (FR) begin
      tick();
      empty = ($urandom % 6) == 0;
      @(negedge clk);
      checks += 3;
      if ({r, g, b} !== e_rgb) begin errors++; $display("FAIL rnd_rgb mt=%0d got=%h exp=%h", mt, {r, g, b}, e_rgb); end
      if (uf !== e_uf) begin errors++; $display("FAIL rnd_uf mt=%0d got=%b exp=%b", mt, uf, e_uf); end
      if (rdreq !== exp_rd()) begin errors++; $display("FAIL rnd_rdreq mt=%0d got=%b exp=%b", mt, rdreq, exp_rd()); end
    end
    empty = 1'b0;
  endtask

  task automatic test_pattern();
    pat_en = 1'b1;
    repeat (FR + 1) begin
      tick();
      @(negedge clk);
      checks += 3;
      if (rdreq !== 1'b0) begin errors++; $display("FAIL pat_rdreq mt=%0d got=%b exp=0", mt, rdreq); end
      if ({r, g, b} !== e_rgb) begin errors++; $display("FAIL pat_rgb h=%0d v=%0d got=%h exp=%h", e_h, e_v, {r, g, b}, e_rgb); end
      if (en !== e_en) begin errors++; $display("FAIL pat_en mt=%0d got=%b exp=%b", mt, en, e_en); end
    end
    pat_en = 1'b0;
  endtask

  task automatic test_pat_toggle();
    repeat (FR) begin
      tick();
      pat_en = ($urandom % 3) == 0;
      empty = ($urandom % 10) == 0;
      @(negedge clk);
      checks += 6;
      if (hsy !== e_hsy) begin errors++; $display("FAIL tog_hsy mt=%0d got=%b exp=%b", mt, hsy, e_hsy); end
      if (vsy !== e_vsy) begin errors++; $display("FAIL tog_vsy mt=%0d got=%b exp=%b", mt, vsy, e_vsy); end
      if (en !== e_en) begin errors++; $display("FAIL tog_en mt=%0d got=%b exp=%b", mt, en, e_en); end
      if (rdreq !== exp_rd()) begin errors++; $display("FAIL tog_rdreq mt=%0d got=%b exp=%b", mt, rdreq, exp_rd()); end
      if ({r, g, b} !== e_rgb) begin errors++; $display("FAIL tog_rgb mt=%0d got=%h exp=%h", mt, {r, g, b}, e_rgb); end
      if (uf !== e_uf) begin errors++; $display("FAIL tog_uf mt=%0d got=%b exp=%b", mt, uf, e_uf); end
    end
    pat_en = 1'b0; empty = 1'b0;
  endtask

  task automatic test_mid_reset();
    int n = 0;
    pat_en = 1'b0;
    empty = 1'b1;
    while (!(mt % HT == 20 && (mt / HT) % VT == VS + VB + 3) && n < FR + 1) begin
      tick();
      n++;
    end
    checks++;
    if (n > FR) begin errors++; $display("FAIL mid_reset_point not reached in %0d cycles", n); end
    rst_n = 1'b0;
    tick();
    empty = 1'b0;
    @(negedge clk);
    checks += 8;
    if (rdreq !== 1'b0) begin errors++; $display("FAIL mid_rdreq got=%b exp=0", rdreq); end
    if (clr !== 1'b1) begin errors++; $display("FAIL mid_clr got=%b exp=1", clr); end
    if (en !== 1'b0) begin errors++; $display("FAIL mid_en got=%b exp=0", en); end
    if (hsy !== 1'b1) begin errors++; $display("FAIL mid_hsy got=%b exp=1", hsy); end
    if (vsy !== 1'b1) begin errors++; $display("FAIL mid_vsy got=%b exp=1", vsy); end
    if ({r, g, b} !== 16'h0) begin errors++; $display("FAIL mid_rgb got=%h exp=0000", {r, g, b}); end
    if (fs !== 1'b0) begin errors++; $display("FAIL mid_fs got=%b exp=0", fs); end
    if (uf !== 1'b0) begin errors++; $display("FAIL mid_uf got=%b exp=0", uf); end
    rst_n = 1'b1;
    repeat (FR) begin
      tick();
      @(negedge clk);
      checks += 4;
      if (fs !== e_fs) begin errors++; $display("FAIL mid_restart_fs mt=%0d got=%b exp=%b", mt, fs, e_fs); end
      if (hsy !== e_hsy) begin errors++; $display("FAIL mid_restart_hsy mt=%0d got=%b exp=%b", mt, hsy, e_hsy); end
      if (rdreq !== exp_rd()) begin errors++; $display("FAIL mid_restart_rdreq mt=%0d got=%b exp=%b", mt, rdreq, exp_rd()); end
      if ({r, g, b} !== e_rgb) begin errors++; $display("FAIL mid_restart_rgb mt=%0d got=%h exp=%h", mt, {r, g, b}, e_rgb); end
    end
  endtask

  task automatic test_small();
    int nrd = 0, nen = 0, nhs = 0, nvs = 0, nfs = 0;
    repeat (77) begin
      tick();
      @(negedge clk);
      nrd += int'(s_rdreq); nen += int'(s_en); nhs += int'(!s_hsy); nvs += int'(!s_vsy); nfs += int'(s_fs);
    end
    checks += 5;
    if (nrd != 32) begin errors++; $display("FAIL small_reads got=%0d exp=32", nrd); end
    if (nen != 32) begin errors++; $display("FAIL small_en got=%0d exp=32", nen); end
    if (nhs != 7) begin errors++; $display("FAIL small_hsy_low got=%0d exp=7", nhs); end
    if (nvs != 11) begin errors++; $display("FAIL small_vsy_low got=%0d exp=11", nvs); end
    if (nfs != 1) begin errors++; $display("FAIL small_frame_start got=%0d exp=1", nfs); end
  endtask

  task automatic test_default();
    int nrd = 0, nen = 0, nhs = 0, nvs = 0, ncl = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (14 * 525) begin
      tick();
      @(negedge clk);
      nrd += int'(d_rdreq); nen += int'(d_en); nhs += int'(!d_hsy); nvs += int'(!d_vsy); ncl += int'(d_clr);
    end
    checks += 5;
    if (nrd != 960) begin errors++; $display("FAIL default_reads got=%0d exp=960", nrd); end
    if (nen != 960) begin errors++; $display("FAIL default_en got=%0d exp=960", nen); end
    if (nhs != 41 * 14) begin errors++; $display("FAIL default_hsy_low got=%0d exp=%0d", nhs, 41 * 14); end
    if (nvs != 5250) begin errors++; $display("FAIL default_vsy_low got=%0d exp=5250", nvs); end
    if (ncl != 5250) begin errors++; $display("FAIL default_clr got=%0d exp=5250", ncl); end
  endtask

  initial begin
    word = 16'($urandom);
    first_word = '0;
    got_first = 1'b0;
    test_reset();
    test_timing();
    test_video();
    test_underflow();
    test_random_empty();
    test_pattern();
    test_pat_toggle();
    test_mid_reset();
    test_small();
    test_default();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
